// File: rtl/tile_map_controller.sv
// tile_map_controller: level tile grid loader, per-pixel tile/offset source and vblank gift collector
module tile_map_controller #(
  parameter int TILE_W   = 80,
  parameter int TILE_H   = 80,
  parameter int COLS     = 8,
  parameter int ROWS     = 6,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        loadReq,
  input  logic [1:0]  levelData,
  output logic [5:0]  levelAddr,
  output logic        loadBusy,
  input  logic        collectReq,
  input  logic [2:0]  collectCol,
  input  logic [2:0]  collectRow,
  output logic        collectAck,
  output logic        collectHit,
  output logic [5:0]  giftsLeft,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [1:0]  Tile_type
);
  localparam int N = COLS * ROWS;
  localparam logic [10:0] TW1 = 11'(TILE_W - 1);
  localparam logic [10:0] TH1 = 11'(TILE_H - 1);
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] C11 = 11'(COLS);
  localparam logic [5:0]  N6   = 6'(N);
  localparam logic [5:0]  LAST = 6'(N - 1);
  localparam logic [5:0]  C6   = 6'(COLS);
  localparam logic [3:0]  C4   = 4'(COLS);
  localparam logic [3:0]  R4   = 4'(ROWS);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t      r_state;
  logic [1:0]  r_grid [N];
  logic [5:0]  r_cnt;
  logic        r_armed;
  logic [10:0] r_offx, r_offy, r_col, r_row;
  logic [10:0] w_offx, w_offy, w_col, w_row;
  logic [5:0]  w_pidx, w_cidx;
  logic        w_xwrap, w_ystep, w_ywrap, w_active, w_cin, w_svc, w_gift;

  // Next tile counters for the current pixel and collect-request decode
  always_comb begin
    w_xwrap  = r_offx == TW1;
    w_offx   = (pixelX == '0 || w_xwrap) ? '0 : r_offx + 11'd1;
    w_col    = (pixelX == '0) ? '0 : r_col + {10'd0, w_xwrap};
    w_ystep  = pixelX == '0;
    w_ywrap  = r_offy == TH1;
    w_offy   = !w_ystep ? r_offy : (pixelY == '0 || w_ywrap) ? '0 : r_offy + 11'd1;
    w_row    = !w_ystep ? r_row : (pixelY == '0) ? '0 : r_row + {10'd0, w_ywrap};
    w_pidx   = 6'(w_row * C11 + w_col);
    w_active = pixelX < HA && pixelY < VA && r_state == RUN;
    w_cin    = {1'b0, collectCol} < C4 && {1'b0, collectRow} < R4;
    w_cidx   = {3'd0, collectRow} * C6 + {3'd0, collectCol};
    w_svc    = r_state == RUN && pixelY >= VA && collectReq && r_armed && !loadReq;
    w_gift   = w_cin && r_grid[w_cidx] == 2'b10;
  end

  // Pixel pipeline: advance tile counters and register the drawer outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_offx    <= '0;
      r_offy    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      offsetX   <= '0;
      offsetY   <= '0;
      Tile_type <= 2'b00;
    end else begin
      r_offx    <= w_offx;
      r_offy    <= w_offy;
      r_col     <= w_col;
      r_row     <= w_row;
      offsetX   <= w_active ? w_offx : '0;
      offsetY   <= w_active ? w_offy : '0;
      Tile_type <= w_active ? r_grid[w_pidx] : 2'b00;
    end

  // Control FSM: ROM load sequencing, gift collection in vblank and its handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < N; i++) r_grid[i] <= 2'b00;
      r_state    <= EMPTY;
      r_cnt      <= '0;
      r_armed    <= 1'b1;
      levelAddr  <= '0;
      loadBusy   <= 1'b0;
      collectAck <= 1'b0;
      collectHit <= 1'b0;
      giftsLeft  <= '0;
    end else begin
      r_armed    <= !collectReq || (r_armed && !w_svc);
      collectAck <= w_svc;
      collectHit <= w_svc && w_gift;
      if (r_state == LOAD) begin
        r_cnt     <= r_cnt + 6'd1;
        levelAddr <= (r_cnt >= LAST) ? LAST : r_cnt + 6'd1;
        if (r_cnt != '0) begin
          r_grid[r_cnt - 6'd1] <= levelData;
          giftsLeft <= giftsLeft + 6'(levelData == 2'b10);
        end
        if (r_cnt == N6) begin
          r_state   <= RUN;
          loadBusy  <= 1'b0;
          levelAddr <= '0;
        end
      end else if (loadReq) begin
        r_state   <= LOAD;
        r_cnt     <= '0;
        levelAddr <= '0;
        loadBusy  <= 1'b1;
        giftsLeft <= '0;
      end else if (w_svc && w_gift) begin
        r_grid[w_cidx] <= 2'b01;
        giftsLeft <= (giftsLeft == '0) ? '0 : giftsLeft - 6'd1;
      end
    end
endmodule

// File: tb/tb_tile_map_controller.sv
// tb_tile_map_controller: randomized scan/collect/load stimulus checked against a behavioural model
module tb_tile_map_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] pixelX, pixelY;
  logic        loadReq;
  logic [1:0]  levelData;
  logic [5:0]  levelAddr;
  logic        loadBusy;
  logic        collectReq;
  logic [2:0]  collectCol, collectRow;
  logic        collectAck, collectHit;
  logic [5:0]  giftsLeft;
  logic [10:0] offsetX, offsetY;
  logic [1:0]  Tile_type;

  always #5 clk = ~clk;

  tile_map_controller dut (
    .clk(clk), .reset(rst), .pixelX(pixelX), .pixelY(pixelY),
    .loadReq(loadReq), .levelData(levelData), .levelAddr(levelAddr), .loadBusy(loadBusy),
    .collectReq(collectReq), .collectCol(collectCol), .collectRow(collectRow),
    .collectAck(collectAck), .collectHit(collectHit), .giftsLeft(giftsLeft),
    .offsetX(offsetX), .offsetY(offsetY), .Tile_type(Tile_type)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] rom_img [48];
  always @(posedge clk) levelData <= rom_img[levelAddr];

  int         m_state;
  int         m_n;
  logic [1:0] m_grid [48];
  int         m_gifts;
  bit         m_armed, m_sync;
  int         p_px, p_py;
  int         e_addr, e_gifts, e_offx, e_offy;
  bit         e_busy, e_ack, e_hit, e_pixok;
  logic [1:0] e_tile;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic m_reset();
    m_state = 0; m_n = 0; m_gifts = 0; m_armed = 1; m_sync = 0;
    for (int k = 0; k < 48; k++) m_grid[k] = 2'b00;
    e_addr = 0; e_gifts = 0; e_offx = 0; e_offy = 0;
    e_busy = 0; e_ack = 0; e_hit = 0; e_pixok = 1; e_tile = 2'b00;
  endtask

  task automatic m_step();
    int px, py, idx;
    bit act, svc;
    px = int'(pixelX);
    py = int'(pixelY);
    p_px = px;
    p_py = py;
    if (px == 0 && py == 0) m_sync = 1;
    act = px < 640 && py < 480 && m_state == 2;
    e_pixok = !act || m_sync;
    e_tile = act ? m_grid[(py / 80) * 8 + px / 80] : 2'b00;
    e_offx = act ? px % 80 : 0;
    e_offy = act ? py % 80 : 0;
    svc = m_state == 2 && py >= 480 && collectReq && m_armed && !loadReq;
    e_ack = svc;
    e_hit = 0;
    idx = int'(collectRow) * 8 + int'(collectCol);
    if (svc && collectRow < 3'd6) begin
      if (m_grid[idx] == 2'b10) begin
        e_hit = 1;
        m_grid[idx] = 2'b01;
        if (m_gifts > 0) m_gifts--;
      end
    end
    m_armed = !collectReq || (m_armed && !svc);
    if (m_state == 1) begin
      m_n++;
      if (m_n == 49) begin
        m_state = 2;
        m_gifts = 0;
        for (int k = 0; k < 48; k++) begin
          m_grid[k] = rom_img[k];
          if (rom_img[k] == 2'b10) m_gifts++;
        end
      end
    end else if (loadReq) begin
      m_state = 1;
      m_n = 0;
    end
    e_busy = m_state == 1;
    e_addr = m_n > 47 ? 47 : m_n;
    if (m_state == 1) begin
      e_gifts = 0;
      for (int k = 0; k < m_n - 1; k++) if (rom_img[k] == 2'b10) e_gifts++;
    end else e_gifts = m_gifts;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("loadBusy", loadBusy, e_busy);
    if (e_busy) chk("levelAddr", levelAddr, e_addr);
    chk("giftsLeft", giftsLeft, e_gifts);
    chk("collectAck", collectAck, e_ack);
    if (e_ack) chk("collectHit", collectHit, e_hit);
    if (e_pixok) begin
      chk("Tile_type", Tile_type, e_tile);
      chk("offsetX", offsetX, e_offx);
      chk("offsetY", offsetY, e_offy);
    end
  end

  initial begin
    int len;
    pixelX = '0;
    pixelY = '0;
    forever for (int y = 0; y < 500; y++) begin
      len = (y == 3 || y == 79 || y == 80 || y == 200 || y == 479) ? 650 : $urandom_range(1, 8);
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        pixelX = 11'(x);
        pixelY = 11'(y);
      end
    end
  end

  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = p_px == x && p_py == y && m_sync && m_state == 2;
    end
    if (!ok) timeout("wait_pix");
  endtask

  task automatic do_load(output int cnt);
    @(negedge clk);
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && (loadBusy || cnt == 0); i++) begin
      if (loadBusy) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_collect(input int col, input int row, output bit hit, output int apy);
    bit got;
    @(negedge clk);
    collectCol = 3'(col);
    collectRow = 3'(row);
    collectReq = 1'b1;
    got = 0;
    hit = 0;
    apy = -1;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (collectAck === 1'b1) begin
        got = 1;
        hit = collectHit;
        apy = p_py;
      end
    end
    collectReq = 1'b0;
    if (!got) timeout("collect_ack");
  endtask

  task automatic pattern_rom();
    for (int k = 0; k < 48; k++) rom_img[k] = 2'(k);
  endtask

  initial begin
    int cnt, apy;
    bit ok, hit, got, saw_busy;
    loadReq = 1'b0;
    collectReq = 1'b0;
    collectCol = '0;
    collectRow = '0;
    pattern_rom();
    repeat (3) @(negedge clk);
    chk("rst_levelAddr", levelAddr, 0);
    chk("rst_loadBusy", loadBusy, 0);
    chk("rst_collectAck", collectAck, 0);
    chk("rst_collectHit", collectHit, 0);
    chk("rst_giftsLeft", giftsLeft, 0);
    chk("rst_offsetX", offsetX, 0);
    chk("rst_offsetY", offsetY, 0);
    chk("rst_Tile_type", Tile_type, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_load(cnt);
    chk("busy_cycles", cnt, 49);
    chk("gifts_after_load", giftsLeft, 12);

    wait_pix(85, 3, ok);
    if (ok) begin
      chk("pin_offx_85", offsetX, 5);
      chk("pin_offy_3", offsetY, 3);
      chk("pin_tile_col1", Tile_type, 2'b01);
    end
    wait_pix(165, 3, ok);
    if (ok) chk("pin_tile_gift", Tile_type, 2'b10);
    wait_pix(640, 3, ok);
    if (ok) begin
      chk("pin_tile_hblank", Tile_type, 2'b00);
      chk("pin_offx_hblank", offsetX, 0);
    end

    for (int i = 0; i < 20000 && pixelY != 11'd100; i++) @(negedge clk);
    do_collect(2, 0, hit, apy);
    chk("ack_in_vblank", apy >= 480, 1);
    chk("gift_hit", hit, 1);
    chk("gifts_after_hit", giftsLeft, 11);
    wait_pix(165, 3, ok);
    if (ok) chk("collected_tile", Tile_type, 2'b01);

    do_collect(1, 0, hit, apy);
    chk("floor_hit", hit, 0);
    chk("floor_gifts", giftsLeft, 11);
    do_collect(7, 7, hit, apy);
    chk("oob_hit", hit, 0);
    chk("oob_gifts", giftsLeft, 11);

    @(negedge clk);
    collectCol = 3'd2;
    collectRow = 3'd0;
    collectReq = 1'b1;
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    got = 0;
    saw_busy = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      if (loadBusy) saw_busy = 1;
      if (collectAck === 1'b1) begin
        got = 1;
        chk("busy_at_ack", loadBusy, 0);
        chk("reload_hit", collectHit, 1);
      end else @(negedge clk);
    end
    collectReq = 1'b0;
    if (!got) timeout("load_collect_ack");
    chk("load_before_ack", saw_busy, 1);
    @(negedge clk);
    chk("reload_gifts", giftsLeft, 11);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 48; k++) rom_img[k] = 2'($urandom_range(0, 3));
      do_load(cnt);
      for (int c = 0; c < 3; c++) begin
        repeat ($urandom_range(0, 3000)) @(negedge clk);
        do_collect(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), hit, apy);
      end
    end

    pattern_rom();
    @(negedge clk);
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_loadBusy", loadBusy, 0);
    chk("abort_levelAddr", levelAddr, 0);
    chk("abort_giftsLeft", giftsLeft, 0);
    chk("abort_Tile_type", Tile_type, 0);
    chk("abort_offsetX", offsetX, 0);
    chk("abort_offsetY", offsetY, 0);
    chk("abort_collectAck", collectAck, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_stays_idle", loadBusy, 0);
    do_load(cnt);
    chk("abort_reload_busy", cnt, 49);
    chk("abort_reload_gifts", giftsLeft, 12);
    wait_pix(165, 3, ok);
    if (ok) chk("abort_reload_tile", Tile_type, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
